// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: address/data widths of the data memory
// and the default store-buffer depth.
package cpu_pkg;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int SB_DEPTH = 4;
endpackage

// File: rtl/sb_match.sv
// Youngest-match search over the store buffer entries: walks from head
// (oldest) towards tail so the last valid match found is the youngest.
import cpu_pkg::*;

module sb_match #(
  parameter  int DEPTH = SB_DEPTH,
  parameter  int AW    = ADDR_W,
  parameter  int DW    = DATA_W,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]    valid,
  input  logic [DEPTH*AW-1:0] addrs,
  input  logic [DEPTH*DW-1:0] datas,
  input  logic [PW-1:0]       head,
  input  logic [AW-1:0]       key,
  output logic                hit,
  output logic [DW-1:0]       data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (addrs[int'(idx)*AW +: AW] == key)) begin
        hit  = 1'b1;
        data = datas[int'(idx)*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the single-port data memory: queues stores,
// drains them when the port is idle and forwards buffered data to loads.
import cpu_pkg::*;

module store_buffer #(
  parameter  int DEPTH = SB_DEPTH,
  parameter  int AW    = ADDR_W,
  parameter  int DW    = DATA_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   MemWrite,
  input  logic                   MemRead,
  input  logic [AW-1:0]          ALUResult,
  input  logic [DW-1:0]          WriteData,
  input  logic                   port_hold,
  input  logic                   fence,
  input  logic [DW-1:0]          MemReadData,
  output logic                   MemWE,
  output logic [AW-1:0]          MemAddr,
  output logic [DW-1:0]          MemWData,
  output logic [DW-1:0]          LoadData,
  output logic                   stall,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  logic [DEPTH*AW-1:0] addr_q;
  logic [DEPTH*DW-1:0] data_q;
  logic [DEPTH-1:0]    valid_q;
  logic [PW-1:0]       head_q, tail_q;
  logic [CW-1:0]       count_q;
  logic                full, drain, enq, hit;
  logic [DW-1:0]       hit_data;
  logic [AW-1:0]       head_addr;
  logic [DW-1:0]       head_data;

  sb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match (
    .valid (valid_q),
    .addrs (addr_q),
    .datas (data_q),
    .head  (head_q),
    .key   (ALUResult),
    .hit   (hit),
    .data  (hit_data)
  );

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_addr = addr_q[int'(head_q)*AW +: AW];
  assign head_data = data_q[int'(head_q)*DW +: DW];

  // Handshake: a request (MemWrite or MemRead) is consumed in any cycle where
  // stall is low; while stall is high upstream must hold the request steady.
  // A store that coincides with a load is dropped in favour of the load.
  assign drain = !empty && !MemRead && !port_hold;
  assign stall = reset_n &&
                 ((MemWrite && !MemRead && full && !drain) ||
                  (MemRead && !hit && port_hold) ||
                  (fence && !empty));
  assign enq   = MemWrite && !MemRead && !stall;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      // Placed after the drain clear so a full-and-drain cycle reusing the
      // head slot leaves the new entry valid.
      if (enq) begin
        valid_q[tail_q]                  <= 1'b1;
        addr_q[int'(tail_q)*AW +: AW]    <= ALUResult;
        data_q[int'(tail_q)*DW +: DW]    <= WriteData;
        tail_q                           <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(enq) - CW'(drain);
    end
  end

  always_comb begin
    MemWE    = drain;
    MemAddr  = drain ? head_addr : ALUResult;
    MemWData = head_data;
    LoadData = hit ? hit_data : MemReadData;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural data memory, a write and
// load scoreboard checked by a negedge monitor, and direct status checks.
module tb_store_buffer;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int W  = AW + DW;

  logic          CLK = 1'b0;
  logic          reset_n;
  logic          MemWrite, MemRead, port_hold, fence;
  logic [AW-1:0] ALUResult;
  logic [DW-1:0] WriteData, MemReadData;
  logic          MemWE, stall, empty;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData, LoadData;
  logic [2:0]    count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] ld_q[$];

  logic [DW-1:0] mem [256];
  bit            written [256];

  always #5 CLK = ~CLK;

  store_buffer dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .port_hold   (port_hold),
    .fence       (fence),
    .MemReadData (MemReadData),
    .MemWE       (MemWE),
    .MemAddr     (MemAddr),
    .MemWData    (MemWData),
    .LoadData    (LoadData),
    .stall       (stall),
    .empty       (empty),
    .count       (count)
  );

  function automatic logic [DW-1:0] preset(input logic [AW-1:0] a);
    case (a)
      8'h30:   return 8'h5C;
      8'h50:   return 8'h3A;
      8'h51:   return 8'h3B;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (MemWE) begin
      mem[MemAddr]     <= MemWData;
      written[MemAddr] <= 1'b1;
    end
  end

  assign MemReadData = written[MemAddr] ? mem[MemAddr] : preset(MemAddr);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops the expected queues whenever the DUT writes memory or
  // completes a load.
  always @(negedge CLK) begin
    if (reset_n) begin
      if (MemRead && MemWrite) begin
        total_cnt++;
        $display("FAIL illegal_req: MemRead and MemWrite both high at %0t", $time);
      end
      if (MemWE) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL mem_write: got %h expected no write", {MemAddr, MemWData});
        end else begin
          chk("mem_write", {MemAddr, MemWData}, exp_q.pop_front());
        end
      end
      if (MemRead && !stall) begin
        if (ld_q.size() == 0) begin
          total_cnt++;
          $display("FAIL load_data: got %h expected no load", LoadData);
        end else begin
          chk("load_data", W'(LoadData), W'(ld_q.pop_front()));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    ALUResult = '0;
    WriteData = '0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_write);
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    ALUResult = a;
    WriteData = d;
    if (expect_write) exp_q.push_back({a, d});
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    port_hold = 1'b0;
    fence     = 1'b0;
    idle_inputs();
    #12;
    chk("reset_count", W'(count), W'(0));
    chk("reset_empty", W'(empty), W'(1));
    chk("reset_memwe", W'(MemWE), W'(0));
    chk("reset_stall", W'(stall), W'(0));
    @(negedge CLK);
    reset_n = 1'b1;
    next_cycle();

    // Single store, drained next cycle.
    MemWrite = 1'b1; ALUResult = 8'h10; WriteData = 8'hAA;
    exp_q.push_back({8'h10, 8'hAA});
    @(negedge CLK);
    chk("t1_stall", W'(stall), W'(0));
    chk("t1_memwe_enq", W'(MemWE), W'(0));
    next_cycle();
    idle_inputs();
    chk("t1_count1", W'(count), W'(1));
    chk("t1_empty0", W'(empty), W'(0));
    @(negedge CLK);
    chk("t1_memwe_drain", W'(MemWE), W'(1));
    next_cycle();
    chk("t1_count0", W'(count), W'(0));
    chk("t1_empty1", W'(empty), W'(1));

    // Fill while the port is held, then a fifth store stalls.
    port_hold = 1'b1;
    store(8'h01, 8'h11, 1'b1);
    store(8'h02, 8'h22, 1'b1);
    store(8'h03, 8'h33, 1'b1);
    store(8'h04, 8'h44, 1'b1);
    chk("t2_count_full", W'(count), W'(4));
    MemWrite = 1'b1; ALUResult = 8'h05; WriteData = 8'h55;
    @(negedge CLK);
    chk("t2_stall_full", W'(stall), W'(1));
    next_cycle();
    chk("t2_count_held", W'(count), W'(4));
    port_hold = 1'b0;
    exp_q.push_back({8'h05, 8'h55});
    @(negedge CLK);
    chk("t2_stall_clear", W'(stall), W'(0));
    chk("t2_memwe_first", W'(MemWE), W'(1));
    next_cycle();
    idle_inputs();
    chk("t2_count_after", W'(count), W'(4));
    repeat (4) next_cycle();
    chk("t2_empty", W'(empty), W'(1));

    // Forwarding from the youngest of two matching entries.
    port_hold = 1'b1;
    store(8'h20, 8'h05, 1'b1);
    store(8'h20, 8'h07, 1'b1);
    MemRead = 1'b1; ALUResult = 8'h20;
    ld_q.push_back(8'h07);
    @(negedge CLK);
    chk("t3_hit_stall", W'(stall), W'(0));
    chk("t3_hit_memwe", W'(MemWE), W'(0));
    next_cycle();

    // Miss while port held stalls; release returns memory data.
    ALUResult = 8'h30;
    @(negedge CLK);
    chk("t4_miss_stall", W'(stall), W'(1));
    next_cycle();
    port_hold = 1'b0;
    ld_q.push_back(8'h5C);
    @(negedge CLK);
    chk("t4_miss_release", W'(stall), W'(0));
    chk("t4_memaddr", W'(MemAddr), W'(8'h30));
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
    chk("t4_empty", W'(empty), W'(1));

    // Fence with three buffered stores.
    port_hold = 1'b1;
    store(8'h40, 8'hC0, 1'b1);
    store(8'h41, 8'hC1, 1'b1);
    store(8'h42, 8'hC2, 1'b1);
    port_hold = 1'b0;
    fence     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t5_fence_stall", W'(stall), W'(1));
      chk("t5_fence_memwe", W'(MemWE), W'(1));
      next_cycle();
    end
    @(negedge CLK);
    chk("t5_fence_empty", W'(empty), W'(1));
    chk("t5_fence_release", W'(stall), W'(0));
    next_cycle();
    fence = 1'b0;

    // Asynchronous reset discards buffered stores.
    port_hold = 1'b1;
    store(8'h50, 8'hE0, 1'b0);
    store(8'h51, 8'hE1, 1'b0);
    chk("t6_count2", W'(count), W'(2));
    #2;
    port_hold = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("t6_rst_count", W'(count), W'(0));
    chk("t6_rst_empty", W'(empty), W'(1));
    chk("t6_rst_memwe", W'(MemWE), W'(0));
    @(negedge CLK);
    reset_n = 1'b1;
    next_cycle();
    MemRead = 1'b1; ALUResult = 8'h50;
    ld_q.push_back(8'h3A);
    next_cycle();
    ALUResult = 8'h51;
    ld_q.push_back(8'h3B);
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();

    chk("writes_outstanding", W'(exp_q.size()), W'(0));
    chk("loads_outstanding", W'(ld_q.size()), W'(0));
    chk("final_mem_20", W'(mem[8'h20]), W'(8'h07));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
